// File: rtl/store_size_ctrl.sv
// Store-size controller: sequences sw directly and sh/sb as read-modify-write,
// merging the B register into the old memory word before a single write strobe.
module store_size_ctrl #(
    parameter int MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] mdr_in,
    input  logic [31:0] b_in,
    output logic        mem_rd,
    output logic        mdr_load,
    output logic        rdc_ctrl,
    output logic        mem_wr,
    output logic [31:0] wr_data,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        IDLE, READ, WAIT, LOAD, MERGE, WRITE, DONE, ERR
    } stateT;

    localparam logic [2:0] WAIT_INIT = 3'(MEM_LAT - 1);

    stateT       stateReg;
    stateT       stateNext;
    logic [2:0]  waitCnt;
    logic [1:0]  sizeReg;
    logic [1:0]  offReg;
    logic [31:0] mergedWord;
    logic        badReq;

    assign badReq = (size == 2'b11)
                 || (size == 2'b01 && addr_lo[0])
                 || (size == 2'b00 && addr_lo != 2'b00);

    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            IDLE: begin
                if (start) begin
                    if (badReq)              stateNext = ERR;
                    else if (size == 2'b00)  stateNext = MERGE;
                    else                     stateNext = READ;
                end
            end
            READ:    stateNext = WAIT;
            WAIT:    if (waitCnt == 3'd0) stateNext = LOAD;
            LOAD:    stateNext = MERGE;
            MERGE:   stateNext = WRITE;
            WRITE:   stateNext = DONE;
            DONE:    stateNext = IDLE;
            ERR:     stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Each byte lane independently picks the store byte or keeps the old memory byte.
    for (genvar gi = 0; gi < 4; gi++) begin : gLane
        logic       hit;
        logic [7:0] src;
        always_comb begin
            hit = 1'b0;
            src = b_in[7:0];
            case (sizeReg)
                2'b00: begin
                    hit = 1'b1;
                    src = b_in[8*gi +: 8];
                end
                2'b01: begin
                    hit = (offReg[1] == 1'(gi / 2));
                    src = b_in[8*(gi % 2) +: 8];
                end
                2'b10:   hit = (offReg == 2'(gi));
                default: hit = 1'b0;
            endcase
        end
        assign mergedWord[8*gi +: 8] = hit ? src : mdr_in[8*gi +: 8];
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stateReg <= IDLE;
            waitCnt  <= 3'd0;
            sizeReg  <= 2'b00;
            offReg   <= 2'b00;
            wr_data  <= 32'd0;
            mem_rd   <= 1'b0;
            mdr_load <= 1'b0;
            rdc_ctrl <= 1'b0;
            mem_wr   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            stateReg <= stateNext;
            if (stateReg == IDLE && start) begin
                sizeReg <= size;
                offReg  <= addr_lo;
            end
            if (stateReg == READ)
                waitCnt <= WAIT_INIT;
            else if (stateReg == WAIT && waitCnt != 3'd0)
                waitCnt <= waitCnt - 3'd1;
            if (stateReg == MERGE)
                wr_data <= mergedWord;
            mem_rd   <= (stateNext == READ);
            mdr_load <= (stateNext == LOAD);
            rdc_ctrl <= (stateNext == MERGE) || (stateNext == WRITE);
            mem_wr   <= (stateNext == WRITE);
            busy     <= (stateNext != IDLE);
            done     <= (stateNext == DONE);
            err      <= (stateNext == ERR);
        end
    end

endmodule

// File: tb/tb_store_size_ctrl.sv
// Directed bench for store_size_ctrl: two instances (MEM_LAT=1 and 3) share stimulus
// and each is checked against cycle/data values worked out by hand.
module tb_store_size_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  size = 2'b00;
    logic [1:0]  addr_lo = 2'b00;
    logic [31:0] mdr_in = 32'd0;
    logic [31:0] b_in = 32'd0;

    logic        memRd[2], mdrLoad[2], rdcCtrl[2], memWr[2], busy[2], done[2], err[2];
    logic [31:0] wrData[2];

    int total = 0;
    int bad = 0;

    int          rdC[2], rd2C[2], ldC[2], wrC[2], dnC[2], erC[2], idleC[2];
    int          nRd[2], nWr[2], overlap[2];
    logic [31:0] dataAtWr[2];
    logic        rdcAtLd[2], rdcAtWr[2];

    localparam int LAT[2] = '{1, 3};

    always #5 clk = ~clk;

    store_size_ctrl #(.MEM_LAT(1)) dut0 (
        .clk(clk), .reset(reset), .start(start), .size(size), .addr_lo(addr_lo),
        .mdr_in(mdr_in), .b_in(b_in), .mem_rd(memRd[0]), .mdr_load(mdrLoad[0]),
        .rdc_ctrl(rdcCtrl[0]), .mem_wr(memWr[0]), .wr_data(wrData[0]),
        .busy(busy[0]), .done(done[0]), .err(err[0])
    );

    store_size_ctrl #(.MEM_LAT(3)) dut1 (
        .clk(clk), .reset(reset), .start(start), .size(size), .addr_lo(addr_lo),
        .mdr_in(mdr_in), .b_in(b_in), .mem_rd(memRd[1]), .mdr_load(mdrLoad[1]),
        .rdc_ctrl(rdcCtrl[1]), .mem_wr(memWr[1]), .wr_data(wrData[1]),
        .busy(busy[1]), .done(done[1]), .err(err[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one request and log, per instance, the cycle (counted from the
    // start-sampling edge) at which each strobe is first seen.
    task automatic runOp(input logic [1:0] sz, input logic [1:0] off,
                         input logic [31:0] mdr, input logic [31:0] b,
                         input bit hold, input int ncyc);
        for (int d = 0; d < 2; d++) begin
            rdC[d] = -1; rd2C[d] = -1; ldC[d] = -1; wrC[d] = -1; dnC[d] = -1;
            erC[d] = -1; idleC[d] = -1; nRd[d] = 0; nWr[d] = 0; overlap[d] = 0;
            dataAtWr[d] = 32'hx; rdcAtLd[d] = 1'bx; rdcAtWr[d] = 1'bx;
        end
        @(negedge clk);
        start = 1'b1; size = sz; addr_lo = off; mdr_in = mdr; b_in = b;
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
        for (int c = 1; c <= ncyc; c++) begin
            for (int d = 0; d < 2; d++) begin
                if (memRd[d]) begin
                    nRd[d]++;
                    if (rdC[d] < 0) rdC[d] = c;
                    else if (rd2C[d] < 0) rd2C[d] = c;
                end
                if (mdrLoad[d] && ldC[d] < 0) begin ldC[d] = c; rdcAtLd[d] = rdcCtrl[d]; end
                if (memWr[d]) begin
                    nWr[d]++;
                    if (wrC[d] < 0) begin wrC[d] = c; dataAtWr[d] = wrData[d]; rdcAtWr[d] = rdcCtrl[d]; end
                end
                if (memRd[d] && memWr[d]) overlap[d]++;
                if (done[d] && dnC[d] < 0) dnC[d] = c;
                if (err[d] && erC[d] < 0) erC[d] = c;
                if (!busy[d] && idleC[d] < 0) idleC[d] = c;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
    endtask

    task automatic checkRmw(input string tag, input logic [31:0] expData);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s[%0d] rd_cycle", tag, d), rdC[d], 1);
            chk($sformatf("%s[%0d] load_cycle", tag, d), ldC[d], 2 + LAT[d]);
            chk($sformatf("%s[%0d] wr_cycle", tag, d), wrC[d], 4 + LAT[d]);
            chk($sformatf("%s[%0d] done_cycle", tag, d), dnC[d], 5 + LAT[d]);
            chk($sformatf("%s[%0d] wr_data", tag, d), dataAtWr[d], expData);
            chk($sformatf("%s[%0d] rdc_at_load", tag, d), 32'(rdcAtLd[d]), 0);
            chk($sformatf("%s[%0d] rdc_at_write", tag, d), 32'(rdcAtWr[d]), 1);
            chk($sformatf("%s[%0d] rd_wr_overlap", tag, d), overlap[d], 0);
            chk($sformatf("%s[%0d] idle_cycle", tag, d), idleC[d], 6 + LAT[d]);
        end
    endtask

    task automatic checkSw(input string tag, input logic [31:0] expData);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s[%0d] rd_count", tag, d), nRd[d], 0);
            chk($sformatf("%s[%0d] wr_cycle", tag, d), wrC[d], 2);
            chk($sformatf("%s[%0d] wr_count", tag, d), nWr[d], 1);
            chk($sformatf("%s[%0d] wr_data", tag, d), dataAtWr[d], expData);
            chk($sformatf("%s[%0d] done_cycle", tag, d), dnC[d], 3);
            chk($sformatf("%s[%0d] idle_cycle", tag, d), idleC[d], 4);
        end
    endtask

    task automatic checkErr(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s[%0d] err_cycle", tag, d), erC[d], 1);
            chk($sformatf("%s[%0d] rd_count", tag, d), nRd[d], 0);
            chk($sformatf("%s[%0d] wr_count", tag, d), nWr[d], 0);
            chk($sformatf("%s[%0d] done_seen", tag, d), dnC[d], -1);
            chk($sformatf("%s[%0d] idle_cycle", tag, d), idleC[d], 2);
        end
    endtask

    initial begin
        int waited;
        // start is high across the first reset edge and must be ignored
        start = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("reset[%0d] busy", d), 32'(busy[d]), 0);
            chk($sformatf("reset[%0d] wr_data", d), wrData[d], 0);
            chk($sformatf("reset[%0d] strobes", d),
                {28'd0, memRd[d], mdrLoad[d], memWr[d], rdcCtrl[d] | done[d] | err[d]}, 0);
        end
        @(negedge clk);
        start = 1'b0;
        reset = 1'b0;
        repeat (2) @(posedge clk);

        runOp(2'b00, 2'b00, 32'h0, 32'hDEADBEEF, 1'b0, 12);
        checkSw("sw", 32'hDEADBEEF);

        runOp(2'b10, 2'b10, 32'h11223344, 32'h000000AA, 1'b0, 12);
        checkRmw("sb_off2", 32'h11AA3344);

        runOp(2'b01, 2'b10, 32'h11223344, 32'h0000BEEF, 1'b0, 12);
        checkRmw("sh_off2", 32'hBEEF3344);

        runOp(2'b01, 2'b00, 32'h11223344, 32'h0000BEEF, 1'b0, 12);
        checkRmw("sh_off0", 32'h1122BEEF);

        runOp(2'b10, 2'b00, 32'h11223344, 32'hFFFFFF55, 1'b0, 12);
        checkRmw("sb_off0", 32'h11223355);

        runOp(2'b10, 2'b11, 32'h11223344, 32'h00000077, 1'b0, 12);
        checkRmw("sb_off3", 32'h77223344);

        runOp(2'b10, 2'b01, 32'hA5A5A5A5, 32'h12345699, 1'b0, 12);
        checkRmw("sb_off1", 32'hA5A599A5);

        runOp(2'b01, 2'b01, 32'h11223344, 32'h0000BEEF, 1'b0, 12);
        checkErr("err_sh_mis");
        runOp(2'b11, 2'b00, 32'h11223344, 32'h0000BEEF, 1'b0, 12);
        checkErr("err_size11");
        runOp(2'b00, 2'b10, 32'h11223344, 32'h0000BEEF, 1'b0, 12);
        checkErr("err_sw_mis");

        // start held high: only the IDLE cycle after done may launch the next op
        runOp(2'b10, 2'b10, 32'h11223344, 32'h000000AA, 1'b1, 12);
        chk("hold[0] done_cycle", dnC[0], 6);
        chk("hold[0] idle_cycle", idleC[0], 7);
        chk("hold[0] second_rd_cycle", rd2C[0], 8);
        chk("hold[0] rd_count", nRd[0], 2);
        chk("hold[1] second_rd_cycle", rd2C[1], 10);
        waited = 0;
        while ((busy[0] || busy[1]) && waited < 40) begin
            @(posedge clk); #1;
            waited++;
        end
        chk("hold drain_timeout", 32'(waited < 40), 1);

        // reset during WRITE of an sb on the MEM_LAT=1 instance (cycle 5)
        @(negedge clk);
        start = 1'b1; size = 2'b10; addr_lo = 2'b10; mdr_in = 32'h11223344; b_in = 32'h000000AA;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        chk("abort pre mem_wr", 32'(memWr[0]), 1);
        chk("abort pre wr_data", wrData[0], 32'h11AA3344);
        #2;
        reset = 1'b1;
        #1;
        chk("abort mem_wr", 32'(memWr[0]), 0);
        chk("abort busy", 32'(busy[0]), 0);
        chk("abort wr_data", wrData[0], 0);
        chk("abort busy_lat3", 32'(busy[1]), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            chk("post_abort no_resume", {30'd0, memWr[0], memWr[1]}, 0);
        end

        runOp(2'b00, 2'b00, 32'h0, 32'hCAFEF00D, 1'b0, 12);
        checkSw("sw_after_abort", 32'hCAFEF00D);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
